// File: rtl/hamm_pkg.sv
// Shared widths, FSM state type and codeword position numbering for the Hamming(7,4) link.
package hamm_pkg;
   localparam int CW_W  = 7;
   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Positions are 1-based in wire order; codeword bit k carries position k+1.
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int D0 = 3;
   localparam int P4 = 4;
   localparam int D1 = 5;
   localparam int D2 = 6;
   localparam int D3 = 7;
endpackage

// File: rtl/hamm_enc74.sv
// Combinational Hamming(7,4) encoder: nibble in, codeword out with bit k = position k+1.
// Zero latency; no flow control.
module hamm_enc74
   import hamm_pkg::*;
(
   input  logic [NIB_W-1:0] i_nib,
   output logic [CW_W-1:0]  o_cw
);
   always_comb begin
      o_cw       = '0;
      o_cw[P1-1] = i_nib[0] ^ i_nib[1] ^ i_nib[3];
      o_cw[P2-1] = i_nib[0] ^ i_nib[2] ^ i_nib[3];
      o_cw[D0-1] = i_nib[0];
      o_cw[P4-1] = i_nib[1] ^ i_nib[2] ^ i_nib[3];
      o_cw[D1-1] = i_nib[1];
      o_cw[D2-1] = i_nib[2];
      o_cw[D3-1] = i_nib[3];
   end
endmodule

// File: rtl/hamm_link_sched.sv
// Round-robin scheduler/framer for the serial Hamming(7,4) link; first bit 1 cycle after arbitration,
// one frame per 7+GAP_CYCLES cycles, requesters hold req until gnt. HAMM_ERR_INJECT_EN adds error injection.
module hamm_link_sched
   import hamm_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] data,
`ifdef HAMM_ERR_INJECT_EN
   input  logic               inj_en,
   input  logic [2:0]         inj_pos,
`endif
   output logic [N_REQ-1:0]   gnt,
   output logic               d_hamm,
   output logic               strobe,
   output logic               busy,
   output logic [2:0]         cur_id
);
   localparam int                GCNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);
   localparam logic [2:0]        LAST_ID   = 3'(N_REQ - 1);

   state_t             r_state;
   logic [2:0]         r_bit;
   logic [GCNT_W-1:0]  r_gcnt;
   logic [2:0]         r_ptr;
   logic [2:0]         r_cur_id;
   logic [CW_W-1:0]    r_cw;
   logic [N_REQ-1:0]   r_gnt;

   logic [2:0]         w_sel;
   logic [2:0]         w_sel_lo;
   logic [2:0]         w_sel_hi;
   logic               w_hit_hi;
   logic [NIB_W-1:0]   w_nib;
   logic [CW_W-1:0]    w_cw;
   logic [CW_W-1:0]    w_inj_mask;
   logic               w_arb;

   // First requester at or above the pointer wins; otherwise wrap to the lowest one.
   always_comb begin
      w_sel_lo = '0;
      w_sel_hi = '0;
      w_hit_hi = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_sel_lo = 3'(i);
            if (3'(i) >= r_ptr) begin
               w_sel_hi = 3'(i);
               w_hit_hi = 1'b1;
            end
         end
      end
      w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
   end

   always_comb begin
      w_nib = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_sel == 3'(i)) w_nib = data[4*i +: 4];
      end
   end

   hamm_enc74 u_enc (
      .i_nib (w_nib),
      .o_cw  (w_cw)
   );

`ifdef HAMM_ERR_INJECT_EN
   always_comb begin
      w_inj_mask = '0;
      if (inj_en && inj_pos != 3'd0) w_inj_mask[inj_pos - 3'd1] = 1'b1;
   end
`else
   assign w_inj_mask = '0;
`endif

   assign w_arb = (|req) && ((r_state == IDLE) || (r_state == GAP && r_gcnt == GCNT_LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_bit    <= '0;
         r_gcnt   <= '0;
         r_ptr    <= '0;
         r_cur_id <= '0;
         r_cw     <= '0;
         r_gnt    <= '0;
      end else begin
         r_gnt <= '0;
         if (w_arb) begin
            r_state  <= SEND;
            r_bit    <= '0;
            r_cw     <= w_cw ^ w_inj_mask;
            r_gnt    <= N_REQ'(1) << w_sel;
            r_cur_id <= w_sel;
            r_ptr    <= (w_sel == LAST_ID) ? 3'd0 : w_sel + 3'd1;
         end else begin
            case (r_state)
               SEND: begin
                  if (r_bit == 3'd6) begin
                     r_state <= GAP;
                     r_gcnt  <= '0;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                  end
               end
               GAP: begin
                  if (r_gcnt == GCNT_LAST) r_state <= IDLE;
                  else                     r_gcnt  <= r_gcnt + 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Outputs decode straight from reset flops so a reset mid-frame drops the line at once.
   assign strobe = (r_state == SEND);
   assign d_hamm = strobe & r_cw[r_bit];
   assign busy   = (r_state != IDLE);
   assign gnt    = r_gnt;
   assign cur_id = r_cur_id;
endmodule

// File: doc/hamm_link_sched.md
# hamm_link_sched

Round-robin scheduler and framer for the serial Hamming(7,4) link. It accepts 4-bit nibbles from up to N_REQ requesters and grants the shared link to one requester at a time. Each granted nibble is encoded to a 7-bit codeword and shifted out one bit per clock on `d_hamm`, framed by `strobe`. It sits upstream of the serial Hamming decoder and is the only driver of that decoder's `d_hamm`/`strobe` inputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 1: strobe-low cycles between frames, minimum 1, because the decoder evaluates on strobe low.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester request, level. Hold until `gnt` is seen.
- `data` input 4*N_REQ: nibble of requester i at `[4i+3:4i]`. Must be stable while `req[i]` is high.
- `gnt` output N_REQ: one-hot, one-cycle pulse when the nibble is captured.
- `d_hamm` output 1: serial codeword bit.
- `strobe` output 1: high for exactly the 7 bit cycles of a frame.
- `busy` output 1: high in SEND and GAP.
- `cur_id` output 3: index of the requester owning the current or last frame.

## Operation
- **Encoding.** Data bits d0..d3 = `data[4i+0..3]`.
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p4 = d1^d2^d3
- **Transmit order.** Positions 1..7 are sent first to last: p1, p2, d0, p4, d1, d2, d3.
- **FSM states:** IDLE, SEND, GAP.
  - IDLE: strobe=0. If any `req` is high, arbitrate and go to SEND.
  - SEND: bit counter 0..6; strobe=1; `d_hamm` = codeword position counter+1. After count 6, go to GAP.
  - GAP: strobe=0, `d_hamm`=0 for GAP_CYCLES cycles. On the last GAP cycle, arbitrate as in IDLE and go straight to SEND if `req` is non-zero. Otherwise go to IDLE.
- **Arbitration.** Round-robin. Search starts at the index after the last granted requester, wrapping from N_REQ-1 to 0. After reset, requester 0 has highest priority.
- **Capture.** `req` and `data` are sampled only at an arbitration edge. A `req` that drops before that edge is never granted. Changes to `data` after capture do not affect the frame in flight.
- **Arithmetic.** The bit counter is 3 bits and never exceeds 6. The GAP counter is sized from GAP_CYCLES. The RR pointer is 3 bits and wraps modulo N_REQ.
- **Reset.** All outputs go to 0 and the FSM goes to IDLE; the RR pointer then points at requester 0.
  - Reset mid-frame aborts the frame immediately. `strobe` falls asynchronously.
  - The downstream decoder then evaluates a partial frame. This is accepted; no retry.

## Timing
- Arbitration edge k → cycle k+1:
  - `gnt[i]`=1 for that cycle only.
  - strobe=1, with `d_hamm` = position 1.
  - `cur_id`=i.
- Frame occupies cycles k+1..k+7, followed by GAP cycles k+8..k+7+GAP_CYCLES.
- Back-to-back frame period is 7+GAP_CYCLES cycles, 8 at default.
- Throughput is 1 nibble per 8 cycles. Latency from `req` sampled to first bit is 1 cycle.
- Requesters may drop or renew `req` at the edge ending the `gnt` cycle. A held `req` is re-arbitrated fairly.

## Configuration
- **`HAMM_ERR_INJECT_EN` defined.** Adds inputs `inj_en` (1) and `inj_pos` (3).
  - Both are sampled at the arbitration edge.
  - If `inj_en`=1 and `inj_pos` is in 1..7, that codeword position is inverted on the wire for that frame.
  - `inj_pos` 0 injects nothing.
- **`HAMM_ERR_INJECT_EN` undefined.** Those ports do not exist and the codeword is always sent unmodified.

## Structure
- **Package `hamm_pkg`:**
  - `CW_W`=7 and `NIB_W`=4.
  - State enum `{IDLE, SEND, GAP}`.
  - Position localparams (P1=1, P2=2, D0=3, P4=4, D1=5, D2=6, D3=7).
- **Sub-module `hamm_enc74`:** combinational nibble → 7-bit codeword in position order. Instantiated once on the RR-selected nibble.

## Test plan
- **Single nibble.** `req[0]`, data 4'b1011 → bit stream 1,0,1,0,1,0,1 under a 7-cycle strobe. Decoder shows 4'hB one cycle after strobe falls.
- **Extreme nibbles.** data 4'h0 → seven 0s. data 4'hF → seven 1s. `gnt` pulses once per frame.
- **Round-robin fairness.** `req`=4'b1111 held → grants 0,1,2,3,0 at 8-cycle spacing. `req`=4'b0101 → 0,2,0,2.
- **Drop before arbitration.** `req[1]` raised then dropped during SEND of requester 0 → no `gnt[1]`; FSM returns to IDLE.
- **Reset mid-frame.** `rst_n` low at bit 4 → strobe, `d_hamm`, `gnt` and `busy` go to 0 immediately. After release, `req`=4'b0110 is granted to 1 first.
- **Error injection (`HAMM_ERR_INJECT_EN`).** data 4'b1011 with `inj_pos`=3 → stream 1,0,0,0,1,0,1. Decoder still displays 4'hB.
